alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Parametrised successor to the single-cycle ALU control decode.
- Accepts one operation per handshake: alu_op plus the R-type funct field and two WIDTH-bit operands. Decodes internally to the 4-bit ALU code and executes.
- Simple ops (ADD/SUB/AND/OR/SLT) complete in one cycle. MULTU runs as an iterative shift-add over WIDTH cycles.
- Sits in the EX stage of the multi-cycle datapath. The controller stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept (high only in IDLE)
- alu_op  in  2  00=ADD, 01=SUB, 10/11=decode funct
- funct  in  6  instruction[5:0]
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  primary result (low product / quotient)
- result_hi  out  WIDTH  upper product / remainder, 0 for simple ops
- alu_code  out  4  decoded ALU code of the op in flight
- illegal  out  1  funct not recognised (valid with out_valid)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready=1, out_valid=0, result=0, result_hi=0, alu_code=ALU_ADD, illegal=0, counter=0. Takes effect immediately, including mid-MULTU; any partial result is discarded.
- Decode: alu_op 00→ADD, 01→SUB. 10/11 use funct[5:0]:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed), 0x19 MULTU.
  - Any other funct: illegal=1, result=0, result_hi=0, latency 1. Never a latch or hold.
- States: IDLE, MUL, DIV (feature only), DONE.
- IDLE: on in_valid&&in_ready, latch operands and decoded code.
  - Simple/illegal op: compute, go to DONE next cycle. Latency 1: out_valid high the cycle after accept.
  - MULTU: init acc=0, multiplicand=op_a, multiplier=op_b, counter=WIDTH; go to MUL.
- MUL: each cycle, if multiplier[0] add multiplicand into the upper half of a 2*WIDTH accumulator, then shift right one; counter decrements. At counter==1 go to DONE.
  - Total latency WIDTH+1 cycles from accept to out_valid.
  - result = product[WIDTH-1:0], result_hi = product[2W-1:W].
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLT result = {WIDTH-1 zeros, signed(a)<signed(b)}.
- DONE: out_valid=1; result, result_hi, alu_code and illegal held stable until out_ready. On out_valid&&out_ready go to IDLE (in_ready=1 the next cycle). No accept in the same cycle as the result drain: throughput ≤1 op per 2 cycles.
- in_ready=0 in MUL/DIV/DONE; in_valid is ignored there. Operands need not be held after accept.
- out_ready high while not DONE: no effect.

Optional Feature:
- Macro ALU_EXEC_DIV_EN.
- Defined: funct 0x1B decodes to DIVU with code ALU_DIVU. Restoring division over WIDTH cycles in state DIV; latency WIDTH+1. result=quotient, result_hi=remainder.
  - Divide by zero: quotient all ones, remainder=op_a; same latency.
- Undefined: 0x1B is illegal (illegal=1, latency 1). DIV state and divider logic absent.

Decomposition:
- constants.v gains ALU_MULTU/ALU_DIVU codes and FUNCT_MULTU (6'h19) / FUNCT_DIVU (6'h1B). Existing ALU_* and FUNCT_* are reused; funct comparisons widen to the full 6 bits.
- State encodings are local to the module.
- One sub-module, alu_decode: combinational alu_op/funct → 4-bit code + illegal. It is the generalised decode, reused by the single-cycle datapath.

Test Plan:
- Reset mid-MULTU: accept MULTU 7×9, assert rst_n=0 at cycle 5 → out_valid=0, in_ready=1 immediately. A new ADD 2+3 then returns result=5.
- Simple ops (WIDTH=32): alu_op=10, funct=0x2A, a=0xFFFFFFFF, b=1 → result=1 one cycle after accept. SUB 5-7 → 0xFFFFFFFE. result_hi=0 in both cases.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → out_valid exactly 33 cycles after accept; result_hi=0xFFFFFFFE, result=0x00000001.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, an in_valid pulse is ignored. Release → IDLE next cycle.
- Illegal funct 0x3F → illegal=1, result=0 after 1 cycle. funct 0x1B → illegal=1 without ALU_EXEC_DIV_EN.
- With ALU_EXEC_DIV_EN: DIVU 100/7 → result=14, result_hi=2 at latency 33. DIVU 5/0 → result=0xFFFFFFFF, result_hi=5.

Source files
------------

// File: rtl/alu_exec_seq_pkg.sv
// Shared ALU codes, funct encodings and alu_op values for the EX-stage ALU.
// The DIVU code is always defined; it only decodes when ALU_EXEC_DIV_EN is set.
package alu_exec_seq_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;

  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

endpackage

// File: rtl/alu_exec_seq_decode.sv
// Combinational alu_op/funct decode to the 4-bit ALU code plus an illegal flag.
// DIVU decodes only when ALU_EXEC_DIV_EN is defined.
module alu_decode
  import alu_exec_seq_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       illegal
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD:   code = ALU_ADD;
          FUNCT_SUB:   code = ALU_SUB;
          FUNCT_AND:   code = ALU_AND;
          FUNCT_OR:    code = ALU_OR;
          FUNCT_SLT:   code = ALU_SLT;
          FUNCT_MULTU: code = ALU_MULTU;
`ifdef ALU_EXEC_DIV_EN
          FUNCT_DIVU:  code = ALU_DIVU;
`endif
          default:     illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Handshaked EX-stage ALU: single-cycle simple ops, iterative shift-add MULTU.
// Define ALU_EXEC_DIV_EN to add restoring DIVU (funct 0x1B).
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       alu_code,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef ALU_EXEC_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t               state_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mplr_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic [3:0]           dec_code;
  logic                 dec_illegal;
  logic [WIDTH-1:0]     simple_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  alu_decode u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  always_comb begin
    simple_res = '0;
    case (dec_code)
      ALU_ADD: simple_res = op_a + op_b;
      ALU_SUB: simple_res = op_a - op_b;
      ALU_AND: simple_res = op_a & op_b;
      ALU_OR:  simple_res = op_a | op_b;
      ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: simple_res = '0;
    endcase
    if (dec_illegal) simple_res = '0;
  end

  // Add into the upper half with carry, then the whole accumulator shifts right.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (mcand_reg & {WIDTH{mplr_reg[0]}})};
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

`ifdef ALU_EXEC_DIV_EN
  // acc holds {remainder, dividend/quotient}; a zero divisor naturally yields
  // an all-ones quotient and the dividend as remainder.
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;

  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - mcand_reg;
  assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                      acc_reg[WIDTH-2:0], div_ge};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      alu_code  <= ALU_ADD;
      illegal   <= 1'b0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            alu_code <= dec_code;
            illegal  <= dec_illegal;
            in_ready <= 1'b0;
            if (!dec_illegal && dec_code == ALU_MULTU) begin
              acc_reg   <= '0;
              mcand_reg <= op_a;
              mplr_reg  <= op_b;
              cnt_reg   <= CNT_W'(WIDTH);
              state_reg <= S_MUL;
`ifdef ALU_EXEC_DIV_EN
            end else if (!dec_illegal && dec_code == ALU_DIVU) begin
              acc_reg   <= {{WIDTH{1'b0}}, op_a};
              mcand_reg <= op_b;
              cnt_reg   <= CNT_W'(WIDTH);
              state_reg <= S_DIV;
`endif
            end else begin
              result    <= simple_res;
              result_hi <= '0;
              out_valid <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_reg  <= mul_next;
          mplr_reg <= mplr_reg >> 1;
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            result    <= mul_next[WIDTH-1:0];
            result_hi <= mul_next[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state_reg <= S_DONE;
          end
        end
`ifdef ALU_EXEC_DIV_EN
        S_DIV: begin
          acc_reg <= div_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            result    <= div_next[WIDTH-1:0];
            result_hi <= div_next[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state_reg <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed scenarios plus randomized ops
// against a plain-arithmetic reference model. Honors ALU_EXEC_DIV_EN.
module tb_alu_exec_seq;
  import alu_exec_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   alu_op = 2'b00;
  logic [5:0]   funct = 6'h00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   alu_code;
  logic         illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .alu_code  (alu_code),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic         ill;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [7:0]   lat;
    logic [3:0]   code;
  } exp_t;

  // Reference: what the operation means, computed with wide arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e = '0;
    e.lat = 8'd1;
    e.code = ALU_ADD;
    if (op == 2'b00) begin
      e.lo = a + b;
    end else if (op == 2'b01) begin
      e.lo = a - b; e.code = ALU_SUB;
    end else begin
      case (f)
        6'h20: e.lo = a + b;
        6'h22: begin e.lo = a - b; e.code = ALU_SUB; end
        6'h24: begin e.lo = a & b; e.code = ALU_AND; end
        6'h25: begin e.lo = a | b; e.code = ALU_OR; end
        6'h2A: begin e.lo = ($signed(a) < $signed(b)) ? W'(1) : W'(0); e.code = ALU_SLT; end
        6'h19: begin
          p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
          e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = 8'(W + 1); e.code = ALU_MULTU;
        end
`ifdef ALU_EXEC_DIV_EN
        6'h1B: begin
          if (b == 0) begin e.lo = '1; e.hi = a; end
          else begin e.lo = a / b; e.hi = a % b; end
          e.lat = 8'(W + 1); e.code = ALU_DIVU;
        end
`endif
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Issue one op from IDLE, wait for the result, capture it and drain it.
  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit rdy_noise,
                        output int lat, output logic [W-1:0] lo, output logic [W-1:0] hi,
                        output logic [3:0] code, output logic ill);
    @(negedge clk);
    alu_op = op; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; alu_op = 2'($urandom); funct = 6'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (rdy_noise) out_ready = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    lo = result; hi = result_hi; code = alu_code; ill = illegal;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, result, result_hi, alu_code, illegal} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, ALU_ADD, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h hi=%h code=%h ill=%b, need rdy=1 vld=0 res=0 hi=0 code=%h ill=0",
               in_ready, out_valid, result, result_hi, alu_code, illegal, ALU_ADD);
    end
    $display("test_reset: rdy=%b vld=%b code=%h", in_ready, out_valid, alu_code);
  endtask

  task automatic test_reset_mid_mul();
    int lat; logic [W-1:0] lo, hi; logic [3:0] code; logic ill;
    @(negedge clk);
    alu_op = 2'b10; funct = FUNCT_MULTU; op_a = 7; op_b = 9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || result_hi !== '0) begin
      failures++;
      $display("FAIL reset_mid_mul: got vld=%b rdy=%b res=%h hi=%h, need vld=0 rdy=1 res=0 hi=0",
               out_valid, in_ready, result, result_hi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 6'h00, 2, 3, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== 1 || lo !== W'(5) || hi !== '0) begin
      failures++;
      $display("FAIL add_after_reset: got lat=%0d res=%h hi=%h, need lat=1 res=5 hi=0", lat, lo, hi);
    end
    $display("test_reset_mid_mul: add 2+3 -> %0d lat=%0d", lo, lat);
  endtask

  task automatic test_simple();
    int lat; logic [W-1:0] lo, hi; logic [3:0] code; logic ill;
    run_op(2'b10, FUNCT_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== 1 || lo !== W'(1) || hi !== '0 || ill !== 1'b0 || code !== ALU_SLT) begin
      failures++;
      $display("FAIL slt_signed: got lat=%0d res=%h hi=%h ill=%b code=%h, need lat=1 res=1 hi=0 ill=0 code=%h",
               lat, lo, hi, ill, code, ALU_SLT);
    end
    $display("test_simple: slt -1<1 -> %h", lo);
    run_op(2'b01, 6'h00, 5, 7, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== 1 || lo !== 32'hFFFF_FFFE || hi !== '0 || code !== ALU_SUB) begin
      failures++;
      $display("FAIL sub_wrap: got lat=%0d res=%h hi=%h code=%h, need lat=1 res=fffffffe hi=0 code=%h",
               lat, lo, hi, code, ALU_SUB);
    end
    $display("test_simple: sub 5-7 -> %h", lo);
  endtask

  task automatic test_multu_max();
    int lat; logic [W-1:0] lo, hi; logic [3:0] code; logic ill;
    run_op(2'b10, FUNCT_MULTU, '1, '1, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== W + 1 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || code !== ALU_MULTU) begin
      failures++;
      $display("FAIL multu_max: got lat=%0d hi=%h lo=%h code=%h, need lat=%0d hi=fffffffe lo=00000001 code=%h",
               lat, hi, lo, code, W + 1, ALU_MULTU);
    end
    $display("test_multu_max: lat=%0d hi=%h lo=%h", lat, hi, lo);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, want;
    a = $urandom; b = $urandom; want = a | b;
    @(negedge clk);
    alu_op = 2'b11; funct = FUNCT_OR; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== want || result_hi !== '0 ||
          alu_code !== ALU_OR || illegal !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b res=%h hi=%h code=%h ill=%b, need vld=1 rdy=0 res=%h hi=0 code=%h ill=0",
                 i, out_valid, in_ready, result, result_hi, alu_code, illegal, want, ALU_OR);
      end
      if (i == 3) begin
        alu_op = 2'b00; op_a = 1; op_b = 1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_pulse: got vld=%b, need vld=0", out_valid);
    end
    $display("test_backpressure: held res=%h then released", want);
  endtask

  task automatic test_illegal();
    int lat; logic [W-1:0] lo, hi; logic [3:0] code; logic ill;
    run_op(2'b10, 6'h3F, '1, '1, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== 1 || ill !== 1'b1 || lo !== '0 || hi !== '0) begin
      failures++;
      $display("FAIL illegal_3f: got lat=%0d ill=%b res=%h hi=%h, need lat=1 ill=1 res=0 hi=0", lat, ill, lo, hi);
    end
    $display("test_illegal: funct 3f ill=%b", ill);
`ifndef ALU_EXEC_DIV_EN
    run_op(2'b11, FUNCT_DIVU, 100, 7, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== 1 || ill !== 1'b1 || lo !== '0 || hi !== '0) begin
      failures++;
      $display("FAIL illegal_1b: got lat=%0d ill=%b res=%h hi=%h, need lat=1 ill=1 res=0 hi=0", lat, ill, lo, hi);
    end
    $display("test_illegal: funct 1b ill=%b", ill);
`endif
  endtask

`ifdef ALU_EXEC_DIV_EN
  task automatic test_divu();
    int lat; logic [W-1:0] lo, hi; logic [3:0] code; logic ill;
    run_op(2'b10, FUNCT_DIVU, 100, 7, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== W + 1 || lo !== W'(14) || hi !== W'(2) || ill !== 1'b0 || code !== ALU_DIVU) begin
      failures++;
      $display("FAIL divu_100_7: got lat=%0d q=%h r=%h ill=%b code=%h, need lat=%0d q=e r=2 ill=0 code=%h",
               lat, lo, hi, ill, code, W + 1, ALU_DIVU);
    end
    $display("test_divu: 100/7 q=%0d r=%0d", lo, hi);
    run_op(2'b10, FUNCT_DIVU, 5, 0, 1'b0, lat, lo, hi, code, ill);
    checks++;
    if (lat !== W + 1 || lo !== '1 || hi !== W'(5)) begin
      failures++;
      $display("FAIL divu_by_zero: got lat=%0d q=%h r=%h, need lat=%0d q=ffffffff r=5", lat, lo, hi, W + 1);
    end
    $display("test_divu: 5/0 q=%h r=%0d", lo, hi);
  endtask
`endif

  task automatic test_random();
    logic [5:0] flist [8];
    int lat; logic [W-1:0] lo, hi, a, b; logic [3:0] code; logic ill;
    logic [1:0] op; logic [5:0] f;
    exp_t e;
    flist = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h19, 6'h1B, 6'h00};
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      f = flist[$urandom_range(0, 7)];
      if (f == 6'h00) f = 6'($urandom);
      a = pick_operand();
      b = pick_operand();
      e = model(op, f, a, b);
      run_op(op, f, a, b, 1'b1, lat, lo, hi, code, ill);
      checks++;
      if (lat !== int'(e.lat) || lo !== e.lo || hi !== e.hi || ill !== e.ill ||
          (!e.ill && code !== e.code)) begin
        failures++;
        $display("FAIL random[%0d] op=%b f=%h a=%h b=%h: got lat=%0d lo=%h hi=%h ill=%b code=%h, need lat=%0d lo=%h hi=%h ill=%b code=%h",
                 n, op, f, a, b, lat, lo, hi, ill, code, e.lat, e.lo, e.hi, e.ill, e.code);
      end
      $display("random[%0d]: op=%b f=%h a=%h b=%h -> lo=%h hi=%h ill=%b lat=%0d", n, op, f, a, b, lo, hi, ill, lat);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_reset_mid_mul();
    test_simple();
    test_multu_max();
    test_backpressure();
    test_illegal();
`ifdef ALU_EXEC_DIV_EN
    test_divu();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
